// File: rtl/spi_ram.sv
// SPI-slave backing RAM: decodes 10-bit words into write/read address and data commands.
// Latency 1 cycle from rx_valid to dout/tx_valid/cmd_err; no backpressure, a word is accepted every cycle.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  cmd_t                 cmd;
  logic [ADDR_SIZE-1:0] addr_in;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_vld;
  logic                 rd_vld;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 wr_en;
  logic [7:0]           rd_dat;

  logic [7:0] mem [MEM_DEPTH];

  assign cmd     = cmd_t'(din[9:8]);
  assign addr_in = din[ADDR_SIZE-1:0];

  // Addresses past MEM_DEPTH are legal on the wire but map to no storage.
  assign wr_in_range = (32'(wr_addr) < MEM_DEPTH);
  assign rd_in_range = (32'(rd_addr) < MEM_DEPTH);

  assign wr_en  = rst_n && rx_valid && (cmd == CMD_WR_DATA) && wr_in_range;
  assign rd_dat = rd_in_range ? mem[rd_addr] : 8'h00;

  // Storage is deliberately outside reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout     <= 8'h00;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_vld   <= 1'b0;
      rd_vld   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (rx_valid) begin
        unique case (cmd)
          CMD_WR_ADDR: begin
            wr_addr <= addr_in;
            wr_vld  <= 1'b1;
          end
          CMD_WR_DATA: begin
            wr_vld  <= 1'b0;
            cmd_err <= !wr_vld;
          end
          CMD_RD_ADDR: begin
            rd_addr <= addr_in;
            rd_vld  <= 1'b1;
          end
          CMD_RD_DATA: begin
            dout     <= rd_dat;
            tx_valid <= 1'b1;
            rd_vld   <= 1'b0;
            cmd_err  <= !rd_vld;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// Bench for spi_ram: two instances (full depth and MEM_DEPTH=200) share directed stimulus and
// are compared every cycle against a word-level model, plus literal expectations per scenario.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout_w [2];
  logic       tx_w   [2];
  logic       err_w  [2];

  int n_checks = 0;
  int n_fail   = 0;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_full (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[0]), .tx_valid(tx_w[0]), .cmd_err(err_w[0])
  );

  spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) u_short (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[1]), .tx_valid(tx_w[1]), .cmd_err(err_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level model: one entry per instance.
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_wa [2];
  int         m_ra [2];
  bit         m_wv [2];
  bit         m_rv [2];
  logic [7:0] e_dout [2];
  bit         e_dout_ok [2];
  bit         e_tx  [2];
  bit         e_err [2];
  bit         m_live = 1'b0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        e_dout[k] = 8'h00; e_dout_ok[k] = 1'b1;
        e_tx[k] = 1'b0; e_err[k] = 1'b0;
        m_wa[k] = 0; m_ra[k] = 0; m_wv[k] = 1'b0; m_rv[k] = 1'b0;
      end else begin
        e_tx[k]  = 1'b0;
        e_err[k] = 1'b0;
        if (rx_valid) begin
          if (din[9:8] == 2'd0) begin
            m_wa[k] = int'(din[7:0]);
            m_wv[k] = 1'b1;
          end else if (din[9:8] == 2'd1) begin
            if (m_wa[k] < depth_of(k)) begin
              m_mem[k][m_wa[k]]   = din[7:0];
              m_known[k][m_wa[k]] = 1'b1;
            end
            e_err[k] = !m_wv[k];
            m_wv[k]  = 1'b0;
          end else if (din[9:8] == 2'd2) begin
            m_ra[k] = int'(din[7:0]);
            m_rv[k] = 1'b1;
          end else begin
            if (m_ra[k] < depth_of(k)) begin
              e_dout[k]    = m_mem[k][m_ra[k]];
              e_dout_ok[k] = m_known[k][m_ra[k]];
            end else begin
              e_dout[k]    = 8'h00;
              e_dout_ok[k] = 1'b1;
            end
            e_tx[k]  = 1'b1;
            e_err[k] = !m_rv[k];
            m_rv[k]  = 1'b0;
          end
        end
      end
    end
    if (!rst_n) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model tx_valid[%0d]", k), 32'(tx_w[k]), 32'(e_tx[k]));
        chk($sformatf("model cmd_err[%0d]", k), 32'(err_w[k]), 32'(e_err[k]));
        if (e_dout_ok[k]) chk($sformatf("model dout[%0d]", k), 32'(dout_w[k]), 32'(e_dout[k]));
      end
    end
  end

  // put: wait a negedge, then present a word; on return the previous word's outputs are visible.
  task automatic put(input logic [9:0] w);
    @(negedge clk);
    din = w;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic lit(input string name, input int k, input logic [7:0] d,
                     input logic tx, input logic er);
    chk($sformatf("%s dout[%0d]", name, k), 32'(dout_w[k]), 32'(d));
    chk($sformatf("%s tx_valid[%0d]", name, k), 32'(tx_w[k]), 32'(tx));
    chk($sformatf("%s cmd_err[%0d]", name, k), 32'(err_w[k]), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) lit("reset", k, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Preload mem[0]=0x5A, then reset again: RAM must survive.
    put(10'h000); put(10'h15A); idle();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // RD_DATA with no RD_ADDR after reset: error, reads mem[0].
    put(10'h3FF); idle();
    for (int k = 0; k < 2; k++) lit("rd_no_addr", k, 8'h5A, 1'b1, 1'b1);
    idle();
    for (int k = 0; k < 2; k++) lit("rd_no_addr hold", k, 8'h5A, 1'b0, 1'b0);

    // Basic write then read.
    put(10'h012); put(10'h1A5); put(10'h212); put(10'h300); idle();
    for (int k = 0; k < 2; k++) lit("basic", k, 8'hA5, 1'b1, 1'b0);

    // Second WR_ADDR overrides the first; then RD_DATA, RD_ADDR, RD_DATA back-to-back.
    put(10'h005); put(10'h111);
    put(10'h005); put(10'h006); put(10'h13C);
    put(10'h206); put(10'h300); put(10'h205);
    for (int k = 0; k < 2; k++) lit("re_addr 0x06", k, 8'h3C, 1'b1, 1'b0);
    put(10'h300);
    for (int k = 0; k < 2; k++) lit("b2b gap", k, 8'h3C, 1'b0, 1'b0);
    idle();
    for (int k = 0; k < 2; k++) lit("re_addr 0x05", k, 8'h11, 1'b1, 1'b0);

    // Address 0xF0: in range for full depth, out of range for depth 200.
    put(10'h0F0); put(10'h177); put(10'h2F0); put(10'h300); idle();
    lit("oor full", 0, 8'h77, 1'b1, 1'b0);
    lit("oor short", 1, 8'h00, 1'b1, 1'b0);

    // Two RD_DATA on consecutive cycles: two pulses, second flagged.
    put(10'h212); put(10'h300); put(10'h300);
    for (int k = 0; k < 2; k++) lit("b2b rd1", k, 8'hA5, 1'b1, 1'b0);
    idle();
    for (int k = 0; k < 2; k++) lit("b2b rd2", k, 8'hA5, 1'b1, 1'b1);

    // Reset wins over an RD_DATA in the same cycle.
    @(negedge clk); rst_n = 1'b0; din = 10'h300; rx_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) lit("rst vs rd", k, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1; rx_valid = 1'b0;
    put(10'h212); put(10'h300); idle();
    for (int k = 0; k < 2; k++) lit("post rst 0x12", k, 8'hA5, 1'b1, 1'b0);
    put(10'h206); put(10'h300); idle();
    for (int k = 0; k < 2; k++) lit("post rst 0x06", k, 8'h3C, 1'b1, 1'b0);

    // WR_DATA with no WR_ADDR: error, still writes at wr_addr (0 after reset).
    put(10'h1EE); idle();
    for (int k = 0; k < 2; k++) chk($sformatf("wr_no_addr cmd_err[%0d]", k), 32'(err_w[k]), 32'd1);
    put(10'h200); put(10'h300); idle();
    for (int k = 0; k < 2; k++) lit("wr_no_addr data", k, 8'hEE, 1'b1, 1'b0);

    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
